// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL divider sequencer.
package pll_seq_pkg;

  localparam int DIV_W = 5;
  localparam int PER_W = 6;
  localparam logic [DIV_W-1:0] DIV_DEFAULT = 5'd8;

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    SETTLE,
    MEASURE,
    LOCKED,
    ERROR
  } state_t;

endpackage

// File: rtl/osc_edge_sync.sv
// Two-flop synchronizer for the asynchronous osc input plus a one-cycle
// rising-edge pulse in the clock domain.
module osc_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic osc,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= osc;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/pll_div_sequencer.sv
// Steps the PLL divider toward a requested target, waits for settling and
// measures the osc period to report lock. PLL_SEQ_SLEW_EN selects unit-step slewing.
module pll_div_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 64,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned TOL        = 1,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             osc,
  input  logic [DIV_W-1:0] req_div,
  input  logic             req_valid,
  output logic             req_ready,
  output logic [DIV_W-1:0] div,
  output logic             locked,
  output logic             lock_err,
  output logic             busy
);

  localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned LW = $clog2(LOCK_CNT + 1);
  localparam logic [PER_W-1:0] PER_MAX = '1;

  state_t           state;
  logic [DIV_W-1:0] target;
  logic [DIV_W-1:0] next_div;
  logic [SW-1:0]    settle_cnt;
  logic [TW-1:0]    tmo_cnt;
  logic [LW-1:0]    lock_cnt;
  logic             armed;
  logic             rise;
  logic [PER_W-1:0] per_cnt;
  logic [PER_W-1:0] div_ext;
  logic [PER_W-1:0] diff;
  logic             in_tol;

  osc_edge_sync u_sync (
    .clock (clock),
    .reset (reset),
    .osc   (osc),
    .rise  (rise)
  );

  // per_cnt holds the cycles elapsed since the last edge; on an edge it is the period.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      per_cnt <= '0;
    else if (rise)
      per_cnt <= PER_W'(1);
    else if (per_cnt != PER_MAX)
      per_cnt <= per_cnt + 1'b1;
  end

  assign div_ext = PER_W'(div);
  assign diff    = (per_cnt >= div_ext) ? (per_cnt - div_ext) : (div_ext - per_cnt);
  assign in_tol  = (diff <= PER_W'(TOL));

`ifdef PLL_SEQ_SLEW_EN
  assign next_div = (target > div) ? (div + 1'b1) : (div - 1'b1);
`else
  assign next_div = target;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= SETTLE;
      div        <= DIV_DEFAULT;
      target     <= DIV_DEFAULT;
      locked     <= 1'b0;
      lock_err   <= 1'b0;
      busy       <= 1'b1;
      req_ready  <= 1'b0;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      lock_cnt   <= '0;
      armed      <= 1'b0;
    end else if (req_valid && req_ready) begin
      target    <= (req_div == '0) ? DIV_W'(1) : req_div;
      locked    <= 1'b0;
      lock_err  <= 1'b0;
      busy      <= 1'b1;
      req_ready <= 1'b0;
      state     <= STEP;
    end else begin
      case (state)
        IDLE, ERROR: ;
        STEP: begin
          if (div != target)
            div <= next_div;
          settle_cnt <= '0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
            settle_cnt <= '0;
            if (div != target) begin
              state <= STEP;
            end else begin
              state    <= MEASURE;
              armed    <= 1'b0;
              lock_cnt <= '0;
              tmo_cnt  <= '0;
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        MEASURE: begin
          // The first edge after settling only arms the counter; its period is partial.
          if (rise)
            armed <= 1'b1;
          if (rise && armed && in_tol && (lock_cnt == LW'(LOCK_CNT - 1))) begin
            state     <= LOCKED;
            locked    <= 1'b1;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            lock_cnt  <= '0;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            state     <= ERROR;
            lock_err  <= 1'b1;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (rise && armed)
              lock_cnt <= in_tol ? (lock_cnt + 1'b1) : '0;
          end
        end
        LOCKED: begin
          // A stalled osc shows up as a saturated counter rather than a late edge.
          if ((rise && !in_tol) || (per_cnt == PER_MAX)) begin
            state     <= MEASURE;
            locked    <= 1'b0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            lock_cnt  <= '0;
            tmo_cnt   <= '0;
            armed     <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
